// File: rtl/rf_mp_if.sv
// rf_mp_if - bus bundle for the multi-port register file with scoreboard.
//
// Signals (named from the register file's point of view):
//   we0/we1, wa0/wa1, wd0/wd1 : two write ports (enable, address, data)
//   ra                        : packed read addresses, port i at slice i
//   rd                        : packed registered read data, port i at slice i
//   sb_set, sb_addr           : scoreboard set request (mark register busy)
//   busy                      : registered busy flag per read port
//
// Modports:
//   master : the requester (drives writes, reads, scoreboard sets)
//   slave  : the register file itself
interface rf_mp_if #(
  parameter int REGISTER_ADDRESS_WIDTH = 5,
  parameter int DATA_WIDTH             = 32,
  parameter int READ_PORTS             = 2
);
  logic                                         we0;
  logic                                         we1;
  logic [REGISTER_ADDRESS_WIDTH-1:0]            wa0;
  logic [REGISTER_ADDRESS_WIDTH-1:0]            wa1;
  logic [DATA_WIDTH-1:0]                        wd0;
  logic [DATA_WIDTH-1:0]                        wd1;
  logic [READ_PORTS*REGISTER_ADDRESS_WIDTH-1:0] ra;
  logic [READ_PORTS*DATA_WIDTH-1:0]             rd;
  logic                                         sb_set;
  logic [REGISTER_ADDRESS_WIDTH-1:0]            sb_addr;
  logic [READ_PORTS-1:0]                        busy;

  modport master (
    output we0, we1, wa0, wa1, wd0, wd1, ra, sb_set, sb_addr,
    input  rd, busy
  );

  modport slave (
    input  we0, we1, wa0, wa1, wd0, wd1, ra, sb_set, sb_addr,
    output rd, busy
  );
endinterface

// File: rtl/rf_mp.sv
// rf_mp - multi-port register file with per-register busy scoreboard.
//
// Two write ports (port 1 wins on an address collision), READ_PORTS
// independent read ports with one cycle of latency, and a busy bit per
// register that is set by sb_set and cleared by any write to that register.
// Register 0 and addresses >= REGISTER_ADDRESS_DEPTH read zero, ignore
// writes and are never busy.
//
// Ports:
//   clk       : single clock, all state changes on posedge
//   a_reset_n : asynchronous active-low reset, clears storage, busy bits,
//               rd and busy
//   bus       : rf_mp_if.slave (write ports, read ports, scoreboard)
//
// Optional feature (macro RF_BYPASS_EN):
//   defined   : a write in the same cycle as a read of the same register is
//               forwarded to rd (wd1 over wd0) and clears that port's busy
//               unless a same-cycle sb_set hits the same register
//   undefined : rd returns the pre-write value and busy the pre-clear value
//
// READ_PORTS is intended for 1..4; REGISTER_ADDRESS_DEPTH for
// 2..2**REGISTER_ADDRESS_WIDTH.
module rf_mp #(
  parameter int REGISTER_ADDRESS_WIDTH = 5,
  parameter int REGISTER_ADDRESS_DEPTH = 32,
  parameter int DATA_WIDTH             = 32,
  parameter int READ_PORTS             = 2
) (
  input  logic    clk,
  input  logic    a_reset_n,
  rf_mp_if.slave  bus
);
  localparam int AW    = REGISTER_ADDRESS_WIDTH;
  localparam int DEPTH = REGISTER_ADDRESS_DEPTH;
  localparam int DW    = DATA_WIDTH;
  localparam int RP    = READ_PORTS;

  // Register 0 has no storage; it is hardwired to zero.
  logic [DW-1:0]    mem [1:DEPTH-1];
  logic [DEPTH-1:1] sb;

  logic [RP*DW-1:0] rd_q;
  logic [RP*DW-1:0] rd_d;
  logic [RP-1:0]    busy_q;
  logic [RP-1:0]    busy_d;

  assign bus.rd   = rd_q;
  assign bus.busy = busy_q;

  // Read mux: comparing against every valid index leaves register 0 and
  // out-of-range addresses at the zero default without a separate check.
  always_comb begin
    rd_d   = '0;
    busy_d = '0;
    for (int i = 0; i < RP; i++) begin
      for (int r = 1; r < DEPTH; r++) begin
        if (bus.ra[i*AW +: AW] == AW'(r)) begin
          rd_d[i*DW +: DW] = mem[r];
          busy_d[i]        = sb[r];
`ifdef RF_BYPASS_EN
          if ((bus.we0 && bus.wa0 == AW'(r)) || (bus.we1 && bus.wa1 == AW'(r))) begin
            rd_d[i*DW +: DW] = (bus.we1 && bus.wa1 == AW'(r)) ? bus.wd1 : bus.wd0;
            // A new producer marked in the same cycle keeps the register busy.
            if (!(bus.sb_set && bus.sb_addr == AW'(r))) begin
              busy_d[i] = 1'b0;
            end
          end
`endif
        end
      end
    end
  end

  always_ff @(posedge clk or negedge a_reset_n) begin
    if (!a_reset_n) begin
      for (int r = 1; r < DEPTH; r++) begin
        mem[r] <= '0;
      end
      sb     <= '0;
      rd_q   <= '0;
      busy_q <= '0;
    end else begin
      rd_q   <= rd_d;
      busy_q <= busy_d;
      for (int r = 1; r < DEPTH; r++) begin
        if (bus.we1 && bus.wa1 == AW'(r)) begin
          mem[r] <= bus.wd1;
        end else if (bus.we0 && bus.wa0 == AW'(r)) begin
          mem[r] <= bus.wd0;
        end
        // Set beats clear: the new producer's result is still outstanding.
        if (bus.sb_set && bus.sb_addr == AW'(r)) begin
          sb[r] <= 1'b1;
        end else if ((bus.we0 && bus.wa0 == AW'(r)) || (bus.we1 && bus.wa1 == AW'(r))) begin
          sb[r] <= 1'b0;
        end
      end
    end
  end
endmodule

// File: tb/tb_rf_mp.sv
module tb_rf_mp;
  localparam int AW    = 5;
  localparam int DEPTH = 24;
  localparam int DW    = 32;
  localparam int RP    = 2;

  logic clk = 1'b0;
  logic a_reset_n = 1'b0;
  always #5 clk = ~clk;

  rf_mp_if #(.REGISTER_ADDRESS_WIDTH(AW), .DATA_WIDTH(DW), .READ_PORTS(RP)) bus ();

  rf_mp #(
    .REGISTER_ADDRESS_WIDTH(AW),
    .REGISTER_ADDRESS_DEPTH(DEPTH),
    .DATA_WIDTH(DW),
    .READ_PORTS(RP)
  ) dut (
    .clk(clk),
    .a_reset_n(a_reset_n),
    .bus(bus)
  );

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;

  // Reference state: plain arrays over the full address space.
  logic [DW-1:0] regs [0:(1<<AW)-1];
  bit            sbm  [0:(1<<AW)-1];
  logic [DW-1:0] exp_rd   [RP];
  bit            exp_busy [RP];

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, req, $time);
    end
  endtask

  function automatic bit in_range(input int a);
    return (a != 0) && (a < DEPTH);
  endfunction

  task automatic model_clear();
    for (int a = 0; a < (1<<AW); a++) begin
      regs[a] = '0;
      sbm[a]  = 1'b0;
    end
    for (int i = 0; i < RP; i++) begin
      exp_rd[i]   = '0;
      exp_busy[i] = 1'b0;
    end
  endtask

  // Called just after a posedge: consumes the inputs the DUT just sampled.
  task automatic model_step();
    int a;
    if (!a_reset_n) begin
      model_clear();
      return;
    end
    for (int i = 0; i < RP; i++) begin
      a = int'(bus.ra[i*AW +: AW]);
      exp_rd[i]   = in_range(a) ? regs[a] : '0;
      exp_busy[i] = in_range(a) ? sbm[a] : 1'b0;
`ifdef RF_BYPASS_EN
      if (in_range(a)) begin
        if (bus.we0 && int'(bus.wa0) == a) begin
          exp_rd[i] = bus.wd0;
          exp_busy[i] = 1'b0;
        end
        if (bus.we1 && int'(bus.wa1) == a) begin
          exp_rd[i] = bus.wd1;
          exp_busy[i] = 1'b0;
        end
        if (bus.sb_set && int'(bus.sb_addr) == a &&
            ((bus.we0 && int'(bus.wa0) == a) || (bus.we1 && int'(bus.wa1) == a)))
          exp_busy[i] = sbm[a];
      end
`endif
    end
    // Writes applied in order so the later port overrides; set applied last.
    if (bus.we0 && in_range(int'(bus.wa0))) begin
      regs[bus.wa0] = bus.wd0;
      sbm[bus.wa0]  = 1'b0;
    end
    if (bus.we1 && in_range(int'(bus.wa1))) begin
      regs[bus.wa1] = bus.wd1;
      sbm[bus.wa1]  = 1'b0;
    end
    if (bus.sb_set && in_range(int'(bus.sb_addr)))
      sbm[bus.sb_addr] = 1'b1;
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
    model_step();
  endtask

  task automatic idle();
    bus.we0 = 0; bus.we1 = 0; bus.wa0 = '0; bus.wa1 = '0;
    bus.wd0 = '0; bus.wd1 = '0; bus.ra = '0;
    bus.sb_set = 0; bus.sb_addr = '0;
  endtask

  function automatic logic [DW-1:0] rd_port(input int i);
    return bus.rd[i*DW +: DW];
  endfunction

  // Reset pulse fully between clock edges; call right after tick().
  task automatic reset_pulse();
    #1 a_reset_n = 1'b0;
    #1;
    check("rst_rd0", rd_port(0), '0);
    check("rst_rd1", rd_port(1), '0);
    check("rst_busy", {30'd0, bus.busy}, '0);
    model_clear();
    a_reset_n = 1'b1;
  endtask

  // Single compare process against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      for (int i = 0; i < RP; i++) begin
        check($sformatf("model_rd%0d", i), rd_port(i), exp_rd[i]);
        check($sformatf("model_busy%0d", i), {31'd0, bus.busy[i]}, {31'd0, exp_busy[i]});
      end
    end
  end

  function automatic logic [AW-1:0] rnd_addr();
    if ($urandom_range(0, 3) == 0) return AW'($urandom_range(0, 31));
    return AW'($urandom_range(0, 7));
  endfunction

  initial begin
    idle();
    model_clear();
    a_reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    check("reset_rd0", rd_port(0), '0);
    check("reset_busy", {30'd0, bus.busy}, '0);
    #1 a_reset_n = 1'b1;
    chk_en = 1'b1;

    // Read 0 and 31 after reset.
    bus.ra = {5'd31, 5'd0};
    tick();
    check("r0_r31_rd0", rd_port(0), '0);
    check("r0_r31_rd1", rd_port(1), '0);
    check("r0_r31_busy", {30'd0, bus.busy}, '0);

    // Basic write then read, latency one.
    idle(); bus.we0 = 1; bus.wa0 = 5'd5; bus.wd0 = 32'hDEADBEEF;
    tick();
    idle(); bus.ra = {5'd0, 5'd5};
    tick();
    check("wr5_rd0", rd_port(0), 32'hDEADBEEF);

    // Collision: port 1 wins.
    idle(); bus.we0 = 1; bus.wa0 = 5'd7; bus.wd0 = 32'h11;
    bus.we1 = 1; bus.wa1 = 5'd7; bus.wd1 = 32'h22;
    tick();
    idle(); bus.ra = {5'd7, 5'd7};
    tick();
    check("coll7_rd0", rd_port(0), 32'h22);
    check("coll7_rd1", rd_port(1), 32'h22);

    // Write to register 0 ignored.
    idle(); bus.we0 = 1; bus.wa0 = 5'd0; bus.wd0 = 32'h55;
    tick();
    idle(); bus.ra = {5'd0, 5'd0};
    tick();
    check("reg0_rd0", rd_port(0), '0);

    // Out-of-range write ignored.
    idle(); bus.we1 = 1; bus.wa1 = 5'd30; bus.wd1 = 32'h99; bus.sb_set = 1; bus.sb_addr = 5'd30;
    tick();
    idle(); bus.ra = {5'd30, 5'd30};
    tick();
    check("oor_rd1", rd_port(1), '0);
    check("oor_busy", {30'd0, bus.busy}, '0);

    // Read during write.
    idle(); bus.we0 = 1; bus.wa0 = 5'd9; bus.wd0 = 32'hA;
    tick();
    idle(); bus.we0 = 1; bus.wa0 = 5'd9; bus.wd0 = 32'hB; bus.ra = {5'd0, 5'd9};
    tick();
`ifdef RF_BYPASS_EN
    check("rdw9_rd0", rd_port(0), 32'hB);
`else
    check("rdw9_rd0", rd_port(0), 32'hA);
`endif

    // Scoreboard sequence on register 3.
    idle(); bus.sb_set = 1; bus.sb_addr = 5'd3;
    tick();
    idle(); bus.ra = {5'd0, 5'd3};
    tick();
    check("sb3_busy0", {31'd0, bus.busy[0]}, 32'd1);
    idle(); bus.we0 = 1; bus.wa0 = 5'd3; bus.wd0 = 32'h1; bus.sb_set = 1; bus.sb_addr = 5'd3;
    bus.ra = {5'd0, 5'd3};
    tick();
    check("sb3_setwr_busy0", {31'd0, bus.busy[0]}, 32'd1);
    idle(); bus.ra = {5'd3, 5'd3};
    tick();
    check("sb3_stays_busy0", {31'd0, bus.busy[0]}, 32'd1);
    check("sb3_stays_busy1", {31'd0, bus.busy[1]}, 32'd1);
    idle(); bus.we1 = 1; bus.wa1 = 5'd3; bus.wd1 = 32'h2;
    tick();
    idle(); bus.ra = {5'd0, 5'd3};
    tick();
    check("sb3_clr_busy0", {31'd0, bus.busy[0]}, 32'd0);
    check("sb3_clr_rd0", rd_port(0), 32'h2);

    // Asynchronous reset between edges.
    idle(); bus.we0 = 1; bus.wa0 = 5'd4; bus.wd0 = 32'h77;
    tick();
    idle(); bus.ra = {5'd0, 5'd4};
    tick();
    check("pre_rst_rd0", rd_port(0), 32'h77);
    reset_pulse();
    tick();
    check("post_rst_rd0", rd_port(0), '0);

    // First write after release lands on the first posedge.
    idle(); bus.we0 = 1; bus.wa0 = 5'd6; bus.wd0 = 32'h1234;
    reset_pulse();
    tick();
    idle(); bus.ra = {5'd6, 5'd0};
    tick();
    check("post_rst_wr6", rd_port(1), 32'h1234);

    // Randomized traffic, one reset pulse in the middle.
    for (int c = 0; c < 3000; c++) begin
      bus.we0 = ($urandom_range(0, 1) == 1);
      bus.we1 = ($urandom_range(0, 2) == 0);
      bus.wa0 = rnd_addr();
      bus.wa1 = rnd_addr();
      bus.wd0 = $urandom;
      bus.wd1 = $urandom;
      bus.sb_set = ($urandom_range(0, 2) == 0);
      bus.sb_addr = rnd_addr();
      bus.ra = {rnd_addr(), rnd_addr()};
      tick();
      if (c == 1500) reset_pulse();
    end

    idle();
    tick();
    @(negedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
